i2s_tx_serializer: RTL

I2S master transmit serializer sitting directly downstream of the TX sample FIFO. Pops one stereo word {left,right} per frame over a valid/ack handshake, generates bit clock (sclk) and word select (lrck), and shifts the data out MSB-first in standard I2S format (data delayed one sclk after lrck changes). Substitutes silence and flags an underrun when no word is available at a frame boundary.

---
 rtl/i2s_tx_serializer_pkg.sv | 15 +
 rtl/i2s_tx_serializer_if.sv | 24 ++
 rtl/i2s_tx_serializer_sclk_gen.sv | 44 ++++
 rtl/i2s_tx_serializer.sv | 117 +++++++++++
 4 files changed

// File: rtl/i2s_tx_serializer_pkg.sv
// rtl/i2s_tx_serializer_pkg.sv - shared constants for the I2S transmit serializer
package i2s_tx_serializer_pkg;

  localparam int I2S_DATA_W = 16;
  localparam int I2S_DIV_W  = 8;

  // lrck level for each channel
  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_TAIL = 2'd2;

endpackage

// File: rtl/i2s_tx_serializer_if.sv
// rtl/i2s_tx_serializer_if.sv - sample FIFO pop handshake between FIFO and serializer
interface i2s_tx_serializer_if
  import i2s_tx_serializer_pkg::*;
#(
  parameter int DATA_W = I2S_DATA_W
);

  logic [2*DATA_W-1:0] data_in;
  logic                data_in_valid;
  logic                data_in_ack;

  modport master (
    output data_in,
    output data_in_valid,
    input  data_in_ack
  );

  modport slave (
    input  data_in,
    input  data_in_valid,
    output data_in_ack
  );

endinterface

// File: rtl/i2s_tx_serializer_sclk_gen.sv
// rtl/i2s_tx_serializer_sclk_gen.sv - bit clock divider with slot-start strobe
// sclk is held low and the counter cleared whenever run is low.
module i2s_sclk_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             sclk,
  output logic             slot_start
);

  logic [DIV_W-1:0] cnt;
  logic             tc;
  logic             rise;

  assign tc         = (cnt == div);
  assign rise       = run & tc & ~sclk;
  // the next edge drops sclk, which is where every slot begins
  assign slot_start = run & tc & sclk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!run) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else begin
      if (tc) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (rise) begin
        sclk <= 1'b1;
      end else if (slot_start) begin
        sclk <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/i2s_tx_serializer.sv
// rtl/i2s_tx_serializer.sv - I2S master transmit serializer fed from the TX sample FIFO
// Pops one {left,right} word per frame and shifts it out MSB-first, one sclk behind lrck.
module i2s_tx_serializer
  import i2s_tx_serializer_pkg::*;
#(
  parameter int DATA_W = I2S_DATA_W,
  parameter int DIV_W  = I2S_DIV_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [DIV_W-1:0]          clk_div,
  i2s_tx_serializer_if.slave        fifo,
  output logic                      i2s_sclk,
  output logic                      i2s_lrck,
  output logic                      i2s_sdout,
  output logic                      underrun,
  output logic                      busy
);

  localparam int FRAME_W = 2 * DATA_W;
  localparam int SLOT_W  = $clog2(FRAME_W);
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(FRAME_W - 1);
  localparam logic [SLOT_W-1:0] SLOT_RIGHT = SLOT_W'(DATA_W);

  logic [1:0]         state;
  logic [DIV_W-1:0]   div_q;
  logic [SLOT_W-1:0]  slot;
  logic [SLOT_W-1:0]  slot_nxt;
  logic [FRAME_W-1:0] shreg;
  logic               dly;
  logic               slot_start;
  logic               idle_start;
  logic               frame_end;
  logic               frame_start;
  logic               fetch;
  logic [FRAME_W-1:0] frame_word;

  assign busy     = (state != ST_IDLE);
  assign slot_nxt = slot + 1'b1;

  i2s_sclk_gen #(
    .DIV_W (DIV_W)
  ) u_sclk_gen (
    .clk        (clk),
    .rst        (rst),
    .run        (busy),
    .div        (div_q),
    .sclk       (i2s_sclk),
    .slot_start (slot_start)
  );

  assign idle_start  = (state == ST_IDLE) & enable;
  assign frame_end   = (state == ST_RUN) & slot_start & (slot == SLOT_LAST);
  assign frame_start = idle_start | (frame_end & enable);

  // gated by rst so nothing is popped or flagged while held in reset
  assign fetch            = frame_start & ~rst;
  assign fifo.data_in_ack = fetch & fifo.data_in_valid;
  assign underrun         = fetch & ~fifo.data_in_valid;
  assign frame_word       = fifo.data_in_valid ? fifo.data_in : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      div_q     <= '0;
      slot      <= '0;
      shreg     <= '0;
      dly       <= 1'b0;
      i2s_lrck  <= 1'b0;
      i2s_sdout <= 1'b0;
    end else begin
      // slot 0 carries the previous frame's last bit from dly
      if (frame_start) begin
        slot      <= '0;
        i2s_lrck  <= CH_LEFT;
        i2s_sdout <= dly;
        shreg     <= frame_word;
        dly       <= frame_word[0];
      end
      case (state)
        ST_IDLE: begin
          if (enable) begin
            state <= ST_RUN;
            div_q <= clk_div;
          end
        end
        ST_RUN: begin
          if (slot_start) begin
            if (slot == SLOT_LAST) begin
              if (!enable) begin
                state     <= ST_TAIL;
                i2s_lrck  <= CH_LEFT;
                i2s_sdout <= dly;
              end
            end else begin
              slot      <= slot_nxt;
              i2s_lrck  <= (slot_nxt >= SLOT_RIGHT) ? CH_RIGHT : CH_LEFT;
              i2s_sdout <= shreg[FRAME_W-1];
              shreg     <= {shreg[FRAME_W-2:0], 1'b0};
            end
          end
        end
        ST_TAIL: begin
          if (slot_start) begin
            state     <= ST_IDLE;
            i2s_lrck  <= CH_LEFT;
            i2s_sdout <= 1'b0;
            dly       <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
